// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one SRAM-like bus between the instruction-fetch port and
//            the data port. One transaction in flight at a time; responses of
//            flushed fetches are absorbed.
// Options  : MEM_ARB_RR_EN - round-robin on simultaneous requests
//            (default: data port always wins).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  // fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_addr_ok,
  output logic          i_data_ok,
  output logic [DW-1:0] i_rdata,
  // data port
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_addr_ok,
  output logic          d_data_ok,
  output logic [DW-1:0] d_rdata,
  // memory bus
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t        state;
  logic          owner_d;   // 1 = data port owns the transaction
  logic          drop;      // in-flight fetch was flushed; absorb response
  logic          wr_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic i_elig;
  logic grant_d;
  logic grant_i;
  logic in_idle;

  // A fetch raised together with a flush is not eligible for a grant
  assign i_elig = i_req & ~i_flush;

`ifdef MEM_ARB_RR_EN
  logic last_d;  // owner of the most recent grant (1 = data)

  // On a tie, the port that did not win last time goes first
  assign grant_d = d_req & ~(i_elig & last_d);
`else
  assign grant_d = d_req;
`endif
  assign grant_i = i_elig & ~grant_d;

  // Gate with resetn so no acceptance is signalled while reset is held
  assign in_idle   = (state == S_IDLE) & resetn;
  assign i_addr_ok = in_idle & grant_i;
  assign d_addr_ok = in_idle & grant_d;

  // Completion pulses: a flush arriving with the response also suppresses it
  assign i_data_ok = (state == S_DATA) & bus_data_ok & ~owner_d & ~drop & ~i_flush;
  assign d_data_ok = (state == S_DATA) & bus_data_ok & owner_d;

  assign i_rdata = bus_rdata;
  assign d_rdata = bus_rdata;

  assign bus_req   = (state == S_ADDR);
  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  // Transaction FSM: grant, hold the address phase, wait for the response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      owner_d <= 1'b0;
      drop    <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_d  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_d) begin
            state   <= S_ADDR;
            owner_d <= 1'b1;
            drop    <= 1'b0;
            wr_q    <= d_wr;
            size_q  <= d_size;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
`ifdef MEM_ARB_RR_EN
            last_d  <= 1'b1;
`endif
          end else if (grant_i) begin
            state   <= S_ADDR;
            owner_d <= 1'b0;
            drop    <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd2;
            addr_q  <= i_addr;
            wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_d  <= 1'b0;
`endif
          end
        end
        S_ADDR: begin
          if (i_flush && !owner_d) drop <= 1'b1;
          if (bus_addr_ok) state <= S_DATA;
        end
        S_DATA: begin
          if (bus_data_ok) begin
            state <= S_IDLE;
            drop  <= 1'b0;
          end else if (i_flush && !owner_d) begin
            drop <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed cycle table,
//            stall/reset and tie sequences, then randomized traffic against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, i_flush;
  logic [31:0] i_addr;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req, d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        ireq, iflush, dreq, dwr;
    logic [1:0]  dsize;
    logic        baok, bdok;
    logic [31:0] rdata;
    logic        e_iaok, e_daok, e_breq, e_idok, e_ddok;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [1:0]  e_size;
  } vec_t;

  function automatic vec_t mk(
    input logic ireq, input logic iflush, input logic dreq, input logic dwr,
    input logic [1:0] dsize, input logic baok, input logic bdok,
    input logic [31:0] rdata, input logic iaok, input logic daok,
    input logic breq, input logic idok, input logic ddok,
    input logic [31:0] addr, input logic wr, input logic [1:0] size);
    vec_t v;
    v.ireq = ireq; v.iflush = iflush; v.dreq = dreq; v.dwr = dwr;
    v.dsize = dsize; v.baok = baok; v.bdok = bdok; v.rdata = rdata;
    v.e_iaok = iaok; v.e_daok = daok; v.e_breq = breq;
    v.e_idok = idok; v.e_ddok = ddok;
    v.e_addr = addr; v.e_wr = wr; v.e_size = size;
    return v;
  endfunction

  vec_t tbl[21];

  // ---------------- reference model ----------------
  // One outstanding transaction record; expected outputs derived per cycle.
  logic        m_busy, m_who, m_acc, m_drop, m_last;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        r_iaok, r_daok;

  task automatic model_reset();
    m_busy = 0; m_who = 0; m_acc = 0; m_drop = 0; m_last = 0;
    m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0;
  endtask

  task automatic model_cycle();
    logic ie, gd, gi;
    logic e_iaok, e_daok, e_breq, e_idok, e_ddok;
    e_iaok = 0; e_daok = 0; e_breq = 0; e_idok = 0; e_ddok = 0;
    if (!m_busy) begin
      ie = i_req && !i_flush;
`ifdef MEM_ARB_RR_EN
      gd = d_req && !(ie && m_last);
`else
      gd = d_req;
`endif
      gi = ie && !gd;
      if (gd) begin
        e_daok = 1; m_busy = 1; m_who = 1; m_acc = 0; m_drop = 0;
        m_wr = d_wr; m_size = d_size; m_addr = d_addr; m_wdata = d_wdata;
        m_last = 1;
      end else if (gi) begin
        e_iaok = 1; m_busy = 1; m_who = 0; m_acc = 0; m_drop = 0;
        m_wr = 0; m_size = 2; m_addr = i_addr; m_wdata = 0;
        m_last = 0;
      end
    end else if (!m_acc) begin
      e_breq = 1;
      chk("rnd_bus_addr", bus_addr, m_addr);
      chk("rnd_bus_wr", {31'b0, bus_wr}, {31'b0, m_wr});
      chk("rnd_bus_size", {30'b0, bus_size}, {30'b0, m_size});
      if (m_wr) chk("rnd_bus_wdata", bus_wdata, m_wdata);
      if (i_flush && !m_who) m_drop = 1;
      if (bus_addr_ok) m_acc = 1;
    end else begin
      if (bus_data_ok) begin
        if (m_who) e_ddok = 1;
        else if (!m_drop && !i_flush) e_idok = 1;
        m_busy = 0;
      end else if (i_flush && !m_who) begin
        m_drop = 1;
      end
    end
    chk("rnd_i_addr_ok", {31'b0, i_addr_ok}, {31'b0, e_iaok});
    chk("rnd_d_addr_ok", {31'b0, d_addr_ok}, {31'b0, e_daok});
    chk("rnd_bus_req",   {31'b0, bus_req},   {31'b0, e_breq});
    chk("rnd_i_data_ok", {31'b0, i_data_ok}, {31'b0, e_idok});
    chk("rnd_d_data_ok", {31'b0, d_data_ok}, {31'b0, e_ddok});
    if (e_idok) chk("rnd_i_rdata", i_rdata, bus_rdata);
    if (e_ddok) chk("rnd_d_rdata", d_rdata, bus_rdata);
    r_iaok = e_iaok;
    r_daok = e_daok;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_flush = 0; i_addr = 0;
    d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    model_reset();
  endtask

  logic exp_tie[3];
  logic tie_dreq[3];
  logic i_pend, d_pend;

  initial begin
    tbl[0]  = mk(1,0,0,0,0, 0,0,32'h0,        1,0,0,0,0, 32'h0,0,0);
    tbl[1]  = mk(0,0,0,0,0, 1,0,32'h0,        0,0,1,0,0, 32'hBFC00000,0,2);
    tbl[2]  = mk(0,0,0,0,0, 0,1,32'h3C1D0000, 0,0,0,1,0, 32'h0,0,0);
    tbl[3]  = mk(0,0,1,1,0, 0,0,32'h0,        0,1,0,0,0, 32'h0,0,0);
    tbl[4]  = mk(0,0,0,1,0, 0,0,32'h0,        0,0,1,0,0, 32'h80000003,1,0);
    tbl[5]  = mk(0,0,0,1,0, 1,0,32'h0,        0,0,1,0,0, 32'h80000003,1,0);
    tbl[6]  = mk(0,0,0,0,0, 0,0,32'h0,        0,0,0,0,0, 32'h0,0,0);
    tbl[7]  = mk(0,0,0,0,0, 0,1,32'h0000DEAD, 0,0,0,0,1, 32'h0,0,0);
    tbl[8]  = mk(1,1,1,0,2, 0,1,32'h0,        0,1,0,0,0, 32'h0,0,0);
    tbl[9]  = mk(0,0,0,0,2, 1,0,32'h0,        0,0,1,0,0, 32'h80000003,0,2);
    tbl[10] = mk(0,0,0,0,0, 0,1,32'h00000055, 0,0,0,0,1, 32'h0,0,0);
    tbl[11] = mk(1,0,0,0,0, 0,0,32'h0,        1,0,0,0,0, 32'h0,0,0);
    tbl[12] = mk(0,0,0,0,0, 1,0,32'h0,        0,0,1,0,0, 32'hBFC00000,0,2);
    tbl[13] = mk(0,1,0,0,0, 0,0,32'h0,        0,0,0,0,0, 32'h0,0,0);
    tbl[14] = mk(0,0,0,0,0, 0,1,32'h12345678, 0,0,0,0,0, 32'h0,0,0);
    tbl[15] = mk(1,0,0,0,0, 0,0,32'h0,        1,0,0,0,0, 32'h0,0,0);
    tbl[16] = mk(0,0,0,0,0, 1,0,32'h0,        0,0,1,0,0, 32'hBFC00000,0,2);
    tbl[17] = mk(0,1,0,0,0, 0,1,32'h00000777, 0,0,0,0,0, 32'h0,0,0);
    tbl[18] = mk(1,0,0,0,0, 0,0,32'h0,        1,0,0,0,0, 32'h0,0,0);
    tbl[19] = mk(0,0,0,0,0, 1,0,32'h0,        0,0,1,0,0, 32'hBFC00000,0,2);
    tbl[20] = mk(0,0,0,0,0, 0,1,32'hCAFEF00D, 0,0,0,1,0, 32'h0,0,0);

    // ---- reset state ----
    resetn = 0;
    idle_inputs();
    #2;
    chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_size", {30'b0, bus_size}, 32'h0);
    do_reset();

    // ---- directed table ----
    for (int k = 0; k < 21; k++) begin
      @(posedge clk); #1;
      i_req = tbl[k].ireq; i_flush = tbl[k].iflush; i_addr = 32'hBFC00000;
      d_req = tbl[k].dreq; d_wr = tbl[k].dwr; d_size = tbl[k].dsize;
      d_addr = 32'h80000003; d_wdata = 32'h000000AB;
      bus_addr_ok = tbl[k].baok; bus_data_ok = tbl[k].bdok;
      bus_rdata = tbl[k].rdata;
      @(negedge clk);
      chk($sformatf("tbl%0d_i_addr_ok", k), {31'b0, i_addr_ok}, {31'b0, tbl[k].e_iaok});
      chk($sformatf("tbl%0d_d_addr_ok", k), {31'b0, d_addr_ok}, {31'b0, tbl[k].e_daok});
      chk($sformatf("tbl%0d_bus_req", k),   {31'b0, bus_req},   {31'b0, tbl[k].e_breq});
      chk($sformatf("tbl%0d_i_data_ok", k), {31'b0, i_data_ok}, {31'b0, tbl[k].e_idok});
      chk($sformatf("tbl%0d_d_data_ok", k), {31'b0, d_data_ok}, {31'b0, tbl[k].e_ddok});
      if (tbl[k].e_breq) begin
        chk($sformatf("tbl%0d_bus_addr", k), bus_addr, tbl[k].e_addr);
        chk($sformatf("tbl%0d_bus_wr", k), {31'b0, bus_wr}, {31'b0, tbl[k].e_wr});
        chk($sformatf("tbl%0d_bus_size", k), {30'b0, bus_size}, {30'b0, tbl[k].e_size});
        if (tbl[k].e_wr) chk($sformatf("tbl%0d_bus_wdata", k), bus_wdata, 32'h000000AB);
      end
      if (tbl[k].e_idok) chk($sformatf("tbl%0d_i_rdata", k), i_rdata, tbl[k].rdata);
      if (tbl[k].e_ddok) chk($sformatf("tbl%0d_d_rdata", k), d_rdata, tbl[k].rdata);
    end

    // ---- stalls, then asynchronous reset mid-ADDR ----
    @(posedge clk); #1;
    idle_inputs();
    i_req = 1; i_addr = 32'hBFC00000;
    @(negedge clk);
    chk("stall_i_addr_ok", {31'b0, i_addr_ok}, 32'h1);
    @(posedge clk); #1 i_req = 0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_bus_req", {31'b0, bus_req}, 32'h1);
      chk("stall_bus_addr", bus_addr, 32'hBFC00000);
      chk("stall_bus_size", {30'b0, bus_size}, 32'h2);
    end
    #2 resetn = 0; i_req = 1;
    #1;
    chk("arst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("arst_bus_addr", bus_addr, 32'h0);
    chk("arst_i_addr_ok", {31'b0, i_addr_ok}, 32'h0);
    @(posedge clk); #1;
    resetn = 1; i_req = 0; bus_data_ok = 1; bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("late_i_data_ok", {31'b0, i_data_ok}, 32'h0);
    chk("late_d_data_ok", {31'b0, d_data_ok}, 32'h0);
    chk("late_bus_req", {31'b0, bus_req}, 32'h0);
    @(posedge clk); #1 bus_data_ok = 0;

    // ---- ties ----
    do_reset();
`ifdef MEM_ARB_RR_EN
    tie_dreq[0] = 1; tie_dreq[1] = 1; tie_dreq[2] = 1;
`else
    tie_dreq[0] = 1; tie_dreq[1] = 0; tie_dreq[2] = 1;
`endif
    exp_tie[0] = 1; exp_tie[1] = 0; exp_tie[2] = 1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      i_req = 1; i_addr = 32'h00001000 + r;
      d_req = tie_dreq[r]; d_wr = 0; d_size = 2; d_addr = 32'h00002000 + r;
      @(negedge clk);
      chk($sformatf("tie%0d_d_addr_ok", r), {31'b0, d_addr_ok}, {31'b0, exp_tie[r]});
      chk($sformatf("tie%0d_i_addr_ok", r), {31'b0, i_addr_ok}, {31'b0, ~exp_tie[r]});
      @(posedge clk); #1;
      i_req = 0; d_req = 0; bus_addr_ok = 1;
      @(posedge clk); #1;
      bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h5A5A0000 + r;
      @(negedge clk);
      chk($sformatf("tie%0d_d_data_ok", r), {31'b0, d_data_ok}, {31'b0, exp_tie[r]});
      chk($sformatf("tie%0d_i_data_ok", r), {31'b0, i_data_ok}, {31'b0, ~exp_tie[r]});
      @(posedge clk); #1 bus_data_ok = 0;
    end

    // ---- randomized traffic against the model ----
    do_reset();
    i_pend = 0; d_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!i_pend && ($urandom % 3 == 0)) begin
        i_pend = 1;
        i_addr = $urandom & 32'hFFFFFFFC;
      end
      if (!d_pend && ($urandom % 3 == 0)) begin
        d_pend  = 1;
        d_wr    = $urandom % 2;
        d_size  = 2'($urandom_range(0, 2));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      i_req       = i_pend;
      d_req       = d_pend;
      i_flush     = ($urandom % 8 == 0);
      bus_addr_ok = ($urandom % 3 != 0);
      bus_data_ok = ($urandom % 2 == 0);
      bus_rdata   = $urandom;
      @(negedge clk);
      model_cycle();
      if (r_iaok) i_pend = 0;
      else if (i_flush) i_pend = 0;
      if (r_daok) d_pend = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
